// File: rtl/uart_tx_fsm.sv
// rtl/uart_tx_fsm.sv - UART transmit frame sequencer driving the TX output mux controls
// One clock equals one bit time; outputs decode only from state, counter and shadow flops.
module uart_tx_fsm #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [1:0]            mux_sel,
   output logic                  ser_data,
   output logic                  par_bit,
   output logic                  busy
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   localparam logic [1:0] SEL_START  = 2'b00;
   localparam logic [1:0] SEL_STOP   = 2'b01;
   localparam logic [1:0] SEL_DATA   = 2'b10;
   localparam logic [1:0] SEL_PARITY = 2'b11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [CNT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] shadow;
   logic                  par_en_q;
   logic                  par_q;
   logic                  accept;

   // Acceptance is only possible while the line is idle or on the stop bit.
   assign accept = Data_Valid && ((state == IDLE) || (state == STOP));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         shadow   <= '0;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
      end else if (accept) begin
         shadow   <= P_DATA;
         par_en_q <= PAR_EN;
         par_q    <= (^P_DATA) ^ PAR_TYP;
      end
   end

   // Counter holds at the last bit on exit rather than wrapping.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         bit_cnt <= '0;
      end else if (state == START) begin
         bit_cnt <= '0;
      end else if ((state == DATA) && (bit_cnt != LAST_BIT)) begin
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (Data_Valid) state_next = START;
         end
         START: begin
            state_next = DATA;
         end
         DATA: begin
            if (bit_cnt == LAST_BIT) begin
               state_next = par_en_q ? PARITY : STOP;
            end
         end
         PARITY: begin
            state_next = STOP;
         end
         STOP: begin
            state_next = Data_Valid ? START : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      mux_sel  = SEL_STOP;
      busy     = 1'b0;
      ser_data = 1'b0;
      case (state)
         IDLE: begin
            mux_sel = SEL_STOP;
         end
         START: begin
            mux_sel = SEL_START;
            busy    = 1'b1;
         end
         DATA: begin
            mux_sel  = SEL_DATA;
            busy     = 1'b1;
            ser_data = shadow[bit_cnt];
         end
         PARITY: begin
            mux_sel = SEL_PARITY;
            busy    = 1'b1;
         end
         STOP: begin
            mux_sel = SEL_STOP;
            busy    = 1'b1;
         end
         default: begin
            mux_sel = SEL_STOP;
         end
      endcase
   end

   assign par_bit = par_q;

endmodule
